// File: rtl/fc_pkg.sv
// Shared constants, FSM encoding and score unpacking for the FC2 result reader.
package fc_pkg;
    localparam int DATA_WIDTH             = 8;
    localparam int DATA_NUM_PER_SRAM_ADDR = 4;
    localparam int NUM_CLASS              = 10;
    localparam int F_ADDR_WIDTH           = 6;
    localparam int WORD_WIDTH             = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR;
    localparam int IDX_WIDTH              = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Element 0 of a word lives in the most significant byte.
    function automatic logic [1:0] lane_of(input logic [IDX_WIDTH-1:0] k);
        return 2'd3 - k[1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pick_score(input logic [WORD_WIDTH-1:0] word,
                                                          input logic [IDX_WIDTH-1:0] k);
        return word[lane_of(k)*DATA_WIDTH +: DATA_WIDTH];
    endfunction
endpackage

// File: rtl/argmax_tracker.sv
// Running signed argmax; first accepted score always wins, ties keep the lower index.
module argmax_tracker
    import fc_pkg::*;
(
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  init,
    input  logic                  upd,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] score,
    input  logic [IDX_WIDTH-1:0]  idx,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [IDX_WIDTH-1:0]  max_class
);
    logic take;

    assign take = upd && (first || ($signed(score) > $signed(max_val)));

    always_ff @(posedge clk) begin
        if (!srstn) begin
            max_val   <= '0;
            max_class <= '0;
        end else if (init) begin
            max_val   <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
            max_class <= '0;
        end else if (take) begin
            max_val   <= score;
            max_class <= idx;
        end
    end
endmodule

// File: rtl/fc_result_reader.sv
// Reads the packed FC2 scores from sram f, streams them out and publishes the argmax.
module fc_result_reader
    import fc_pkg::*;
(
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    fc2_done,
    output logic [F_ADDR_WIDTH-1:0] sram_raddr_f,
    input  logic [WORD_WIDTH-1:0]   sram_rdata_f,
    output logic                    score_valid,
    input  logic                    score_ready,
    output logic [DATA_WIDTH-1:0]   score_data,
    output logic [IDX_WIDTH-1:0]    score_idx,
    output logic                    result_valid,
    output logic [IDX_WIDTH-1:0]    result_class,
    output logic [DATA_WIDTH-1:0]   result_max,
    output logic                    busy
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    state_t                  state;
    logic [IDX_WIDTH-1:0]    idx;
    logic [F_ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0]   word_buf;
    logic                    start_pending;
    logic                    start;
    logic                    handshake;
    logic [DATA_WIDTH-1:0]   trk_max;
    logic [IDX_WIDTH-1:0]    trk_class;

    assign start     = fc2_done || start_pending;
    assign handshake = (state == ST_EMIT) && score_ready;

    assign sram_raddr_f = addr;
    assign score_valid  = (state == ST_EMIT);
    assign score_data   = pick_score(word_buf, idx);
    assign score_idx    = idx;
    assign busy         = (state != ST_IDLE);

    argmax_tracker u_argmax (
        .clk       (clk),
        .srstn     (srstn),
        .init      ((state == ST_IDLE) && start),
        .upd       (handshake),
        .first     (idx == '0),
        .score     (score_data),
        .idx       (idx),
        .max_val   (trk_max),
        .max_class (trk_class)
    );

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state         <= ST_IDLE;
            idx           <= '0;
            addr          <= '0;
            word_buf      <= '0;
            start_pending <= 1'b0;
            result_valid  <= 1'b0;
            result_class  <= '0;
            result_max    <= '0;
        end else begin
            // Starts arriving while busy (including the DONE cycle) collapse into one rerun.
            if (state == ST_IDLE) start_pending <= 1'b0;
            else                  start_pending <= start_pending || fc2_done;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_FETCH;
                        result_valid <= 1'b0;
                        addr         <= '0;
                        idx          <= '0;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    word_buf <= sram_rdata_f;
                    state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (score_ready) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else if (idx[1:0] == 2'd3) begin
                            state <= ST_FETCH;
                            addr  <= addr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    result_valid <= 1'b1;
                    result_class <= trk_class;
                    result_max   <= trk_max;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/fc_result_reader.md
Name: fc_result_reader

Overview:
- Consumer at the far end of the FC2 output path; reads the 10 FC2 scores that the FC stage packed into sram f.
- Starts on the fc2_done pulse and streams each signed 8-bit score out over a valid/ready handshake.
- Tracks a running argmax and publishes the winning class index and its score as the LeNet classification result.

Parameters:
- DATA_WIDTH, 8, bit width of one score (signed two's complement).
- DATA_NUM_PER_SRAM_ADDR, 4, scores packed per sram f word.
- NUM_CLASS, 10, number of FC2 outputs to read.
- F_ADDR_WIDTH, 6, sram f address width.

Ports:
- clk  in  1  clock.
- srstn  in  1  synchronous active-low reset.
- fc2_done  in  1  one-cycle start pulse; all FC2 results are committed in sram f.
- sram_raddr_f  out  F_ADDR_WIDTH  sram f read address, registered.
- sram_rdata_f  in  DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR  sram f read data, valid one cycle after the address.
- score_valid  out  1  score_data/score_idx valid.
- score_ready  in  1  downstream accepts the score.
- score_data  out  DATA_WIDTH  current score.
- score_idx  out  4  class index of the current score.
- result_valid  out  1  argmax result valid; held until the next start.
- result_class  out  4  index of the maximum score.
- result_max  out  DATA_WIDTH  maximum score value.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset srstn: synchronous, active-low; clock clk. All outputs reset to 0, state IDLE, pending start cleared, word buffer cleared.
- Packing: score k is at address k/4, byte lane L = 3-(k%4), bits [8L+7:8L]. Element 0 of each word is in the MSB byte.
- States:
  - IDLE: go to FETCH if fc2_done or start_pending. On start: clear result_valid, set addr 0, set idx 0, set max to the most negative value (8'h80), set class 0.
  - FETCH: sram_raddr_f holds the current word address (1 cycle); go to WAIT.
  - WAIT: sram_rdata_f is valid; latch the full word into the word buffer at the end of the cycle; go to EMIT.
  - EMIT: score_valid=1. score_data is the buffer byte selected by idx%4; score_idx=idx.
    - Hold outputs stable while score_ready=0.
    - On handshake (valid&ready), update the argmax:
      - if score > max (signed compare), or this is the first score (idx==0): max<=score, class<=idx.
      - A tie keeps the lower index.
    - Then idx<=idx+1. Next state:
      - idx==NUM_CLASS-1: DONE.
      - idx%4==3: FETCH with addr+1.
      - otherwise stay in EMIT.
  - DONE: result_valid<=1, result_class/result_max drive the final argmax; go to IDLE the next cycle. result_valid then stays high in IDLE.
- Latency: fc2_done sampled at cycle T gives addr 0 driven at T+1, data at T+2, first score_valid at T+3. With score_ready tied high, the 10 scores finish at T+16 and result_valid rises at T+18.
- The last word (address 2) uses only lanes 3 and 2; lanes 1 and 0 are never emitted.
- fc2_done while busy: latched into start_pending and serviced on the first IDLE cycle after DONE. Multiple pulses collapse into one.
- fc2_done in the same cycle as the DONE→IDLE transition is also captured by start_pending.
- srstn low mid-operation: immediate return to IDLE on the next edge, outputs cleared, no result_valid.
- sram_raddr_f holds its last value while outside FETCH/WAIT. Reads are side-effect free.

Decomposition:
- Shared package (fc_pkg): DATA_WIDTH, DATA_NUM_PER_SRAM_ADDR, NUM_CLASS, F_ADDR_WIDTH, the state encoding (IDLE=0, FETCH=1, WAIT=2, EMIT=3, DONE=4), and the byte-lane extraction function (lane = 3 - k%4).
- Sub-module: argmax_tracker. Holds max/class registers and implements signed compare, tie rule and init-on-first.

Test Plan:
- Scores {3,-5,7,1, 0,12,-128,12, 2,4}, fc2_done pulse, score_ready=1 → ten handshakes with score_idx 0..9 at T+3..T+12 plus fetch gaps; result_class=5, result_max=12 (tie at idx 7 ignored), result_valid at T+18.
- All scores -128 → result_class=0, result_max=8'h80.
- score_ready toggles 1,0,0,1 repeatedly → score_data/score_idx stable during stalls, no duplicate or dropped index, same final result as the ready=1 run.
- Second fc2_done during EMIT → after DONE, reader restarts with result_valid cleared and addr back to 0; exactly one extra run.
- srstn low at idx 4 → all outputs 0 the next cycle, state IDLE; a new fc2_done gives a clean full run.
- Max at idx 9 (word 2, lane 2) = 8'h7F, others 0 → result_class=9, lanes 1/0 of word 2 never appear on score_data.
